// File: rtl/divisor_pkg.sv
// divisor_pkg: shared state encoding and sizing helpers for the sequential divider
package divisor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);
endpackage

// File: rtl/divisor_paso.sv
// divisor_paso: one combinational restoring-division step
module divisor_paso
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_nxt,
  output logic             q_bit
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] bx;
  logic           unused_r_msb;
  assign unused_r_msb = r[WIDTH];
  assign t = {r[WIDTH-1:0], q_msb};
  assign bx = {1'b0, b};
  assign q_bit = t >= bx;
  assign r_nxt = q_bit ? t - bx : t;
endmodule

// File: rtl/divisor_seq.sv
// divisor_seq: sequential unsigned restoring divider returning {remainder, quotient}
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done,
  output logic               div_cero,
  output logic               cero,
  output logic               negativo
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_nxt;
  logic             q_bit;
  logic [CW-1:0]    cnt;
  divisor_paso #(.WIDTH(WIDTH)) u_paso (
    .r     (r),
    .q_msb (q[WIDTH-1]),
    .b     (b_r),
    .r_nxt (r_nxt),
    .q_bit (q_bit)
  );
  assign cero = C == '0;
  assign negativo = C[2*WIDTH-1];
  // control FSM plus quotient/remainder datapath, one quotient bit per RUN edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      q        <= '0;
      b_r      <= '0;
      r        <= '0;
      cnt      <= '0;
      C        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_cero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (B == '0) begin
              C        <= {A, {WIDTH{1'b1}}};
              div_cero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              q     <= A;
              b_r   <= B;
              r     <= '0;
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          q   <= {q[WIDTH-2:0], q_bit};
          r   <= r_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            C        <= {r_nxt[WIDTH-1:0], q[WIDTH-2:0], q_bit};
            div_cero <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
